// File: rtl/zprize_mul_sched_pkg.sv
// Shared definitions for the multiplier issue scheduler: id width helper,
// sideband field offsets and the sideband word layout.
package zprize_mul_sched_pkg;

    function automatic int sched_idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int SB_TAG_LSB = 0;

    function automatic int sb_id_lsb(input int tw);
        return tw;
    endfunction

    function automatic int sb_vld(input int tw, input int idw);
        return tw + idw;
    endfunction

    // Sideband word at the default geometry (N = 4, TW = 8).
    localparam int SB_DEF_TW  = 8;
    localparam int SB_DEF_IDW = 2;

    typedef struct packed {
        logic                  vld;
        logic [SB_DEF_IDW-1:0] id;
        logic [SB_DEF_TW-1:0]  tag;
    } sb_word_t;

endpackage

// File: rtl/zprize_rr_arb.sv
// N-way round-robin arbiter: grants the first request at or after the
// pointer, then moves the pointer just past the winner.
module zprize_rr_arb
    import zprize_mul_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N-1:0]            req,
    output logic [N-1:0]            gnt,
    output logic [sched_idw(N)-1:0] gnt_idx,
    output logic                    gnt_vld
);

    localparam int IDW = sched_idw(N);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        ptr_d   = ptr_q;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDW'((int'(ptr_q) + k) % N);
            if (en && !gnt_vld && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_vld   = 1'b1;
                ptr_d     = IDW'((int'(cand) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/zprize_mul_sched.sv
// Shares one pipelined multiplier among N requesters: round-robin issue,
// sideband-tagged return steering, warm-up masking and latency checking.
module zprize_mul_sched
    import zprize_mul_sched_pkg::*;
#(
    parameter int W   = 384,
    parameter int N   = 4,
    parameter int TW  = 8,
    parameter int LAT = 10,
    parameter int M   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*W-1:0]  req_a,
    input  logic [N*W-1:0]  req_b,
    input  logic [N*TW-1:0] req_tag,
    output logic [N-1:0]    rsp_valid,
    output logic [2*W-1:0]  rsp_data,
    output logic [TW-1:0]   rsp_tag,
    output logic [W-1:0]    mul_in0,
    output logic [W-1:0]    mul_in1,
    output logic [M-1:0]    mul_m_i,
    input  logic [M-1:0]    mul_m_o,
    input  logic [2*W-1:0]  mul_out0,
    output logic            busy,
    output logic            err_lat
);

    localparam int IDW    = sched_idw(N);
    localparam int SBW    = 1 + IDW + TW;
    localparam int ID_LSB = sb_id_lsb(TW);
    localparam int VLD    = sb_vld(TW, IDW);
    localparam int WUW    = $clog2(LAT + 1);
    localparam int CW     = $clog2(LAT + 3);

    logic [WUW-1:0] wu_q, wu_d;
    logic [W-1:0]   in0_q, in0_d, in1_q, in1_d;
    logic [SBW-1:0] sb_q, sb_d;
    logic [LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [N-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*W-1:0] rsp_data_q, rsp_data_d;
    logic [TW-1:0]  rsp_tag_q, rsp_tag_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           warm, issue_en, gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic           mo_vld, id_ok;
    logic [IDW-1:0] mo_id;
    logic [TW-1:0]  mo_tag;

    assign warm     = (wu_q != '0);
    assign issue_en = en & ~warm;

    zprize_rr_arb #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (issue_en),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign mo_vld = mul_m_o[VLD];
    assign mo_id  = mul_m_o[ID_LSB +: IDW];
    assign mo_tag = mul_m_o[SB_TAG_LSB +: TW];
    assign id_ok  = (int'(mo_id) < N);

    if (M > SBW) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^mul_m_o[M-1:SBW];
    end

    // Operand registers hold on idle cycles so the multiplier inputs do not toggle.
    always_comb begin
        in0_d = in0_q;
        in1_d = in1_q;
        sb_d  = '0;
        if (gnt_vld) begin
            in0_d = req_a[int'(gnt_idx)*W +: W];
            in1_d = req_b[int'(gnt_idx)*W +: W];
            sb_d  = {1'b1, gnt_idx, req_tag[int'(gnt_idx)*TW +: TW]};
        end
    end

    always_comb begin
        wu_d          = warm ? wu_q - WUW'(1) : wu_q;
        vld_pipe_d    = '0;
        vld_pipe_d[0] = sb_q[SBW-1];
        for (int i = 1; i < LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    // Sideband is trusted only once the warm-up has flushed the multiplier.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        err_d       = err_q;
        if (!warm) begin
            if (mo_vld && id_ok) begin
                rsp_valid_d = {{(N-1){1'b0}}, 1'b1} << mo_id;
                rsp_data_d  = mul_out0;
                rsp_tag_d   = mo_tag;
            end
            if ((vld_pipe_q[LAT-1] != mo_vld) || (mo_vld && !id_ok)) err_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({gnt_vld, |rsp_valid_d})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wu_q        <= WUW'(LAT);
            in0_q       <= '0;
            in1_q       <= '0;
            sb_q        <= '0;
            vld_pipe_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wu_q        <= wu_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            sb_q        <= sb_d;
            vld_pipe_q  <= vld_pipe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mul_in0   = in0_q;
    assign mul_in1   = in1_q;
    assign mul_m_i   = M'(sb_q);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign err_lat   = err_q;
    assign busy      = warm | (cnt_q != '0);

endmodule

// File: tb/tb_zprize_mul_sched.sv
// Bench for zprize_mul_sched: behavioural multiplier, queue-based response
// model checked every cycle, plus literal expectations for the key scenarios.
module tb_zprize_mul_sched;
    import zprize_mul_sched_pkg::*;

    localparam int W = 384, N = 4, TW = 8, LAT = 10, M = 32, PW = 2 * W;

    logic clk = 1'b0;
    logic rst, en;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [N*W-1:0]  req_a, req_b;
    logic [N*TW-1:0] req_tag;
    logic [PW-1:0]   rsp_data, mul_out0;
    logic [TW-1:0]   rsp_tag;
    logic [W-1:0]    mul_in0, mul_in1;
    logic [M-1:0]    mul_m_i, mul_m_o;
    logic            busy, err_lat;

    always #5 clk = ~clk;

    zprize_mul_sched #(.W(W), .N(N), .TW(TW), .LAT(LAT), .M(M)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_m_i(mul_m_i),
        .mul_m_o(mul_m_o), .mul_out0(mul_out0),
        .busy(busy), .err_lat(err_lat)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Behavioural multiplier with unreset sideband; fmode 1 fills garbage, 2 clears.
    logic [M-1:0]  pm [16];
    logic [PW-1:0] pp [16];
    int mlat = LAT;
    int fmode = 1;
    assign mul_m_o  = pm[mlat-1];
    assign mul_out0 = pp[mlat-1];

    always @(posedge clk) begin
        if (fmode == 1) begin
            for (int i = 0; i < 16; i++) begin pm[i] <= $urandom; pp[i] <= '0; end
        end else if (fmode == 2) begin
            for (int i = 0; i < 16; i++) begin pm[i] <= '0; pp[i] <= '0; end
        end else begin
            pm[0] <= mul_m_i;
            pp[0] <= {{W{1'b0}}, mul_in0} * {{W{1'b0}}, mul_in1};
            for (int i = 1; i < 16; i++) begin pm[i] <= pm[i-1]; pp[i] <= pp[i-1]; end
        end
    end

    // Per-requester op lists; the driver presents the head until it is granted.
    logic [W-1:0]  op_a [N][64];
    logic [W-1:0]  op_b [N][64];
    logic [TW-1:0] op_t [N][64];
    int op_cnt [N];
    int op_hd  [N];

    task automatic add_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] t);
        op_a[r][op_cnt[r]] = a;
        op_b[r][op_cnt[r]] = b;
        op_t[r][op_cnt[r]] = t;
        op_cnt[r]++;
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [N-1:0] g;
        req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
        forever begin
            @(negedge clk);
            g = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (g[i]) op_hd[i]++;
                if (op_hd[i] < op_cnt[i]) begin
                    req_valid[i]          = 1'b1;
                    req_a[i*W +: W]       = op_a[i][op_hd[i]];
                    req_b[i*W +: W]       = op_b[i][op_hd[i]];
                    req_tag[i*TW +: TW]   = op_t[i][op_hd[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Cycles since reset release; warm-up spans k = 0..LAT-1.
    int k;
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    typedef struct {
        int            id;
        logic [PW-1:0] p;
        logic [TW-1:0] tag;
        int            due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int ptr_m = 0;
    int exp_idx, cc;
    logic [N-1:0] exp_rdy;
    logic exp_busy;
    bit chk_on = 1;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            ptr_m = 0;
        end else if (chk_on) begin
            exp_idx = -1;
            if (en && k >= LAT)
                for (int j = 0; j < N; j++) begin
                    cc = (ptr_m + j) % N;
                    if (exp_idx < 0 && req_valid[cc]) exp_idx = cc;
                end
            exp_rdy = (exp_idx >= 0) ? (4'b0001 << exp_idx) : 4'b0000;
            chk("req_ready", req_ready, exp_rdy);
            exp_busy = (k < LAT) || (q.size() > 0 && q[q.size()-1].due > k);
            chk("busy", busy, exp_busy);
            chk("err_lat", err_lat, 0);
            if (q.size() > 0 && q[0].due == k) begin
                chk("rsp_valid", rsp_valid, 4'b0001 << q[0].id);
                chk("rsp_data", rsp_data, q[0].p);
                chk("rsp_tag", rsp_tag, q[0].tag);
                void'(q.pop_front());
            end else begin
                chk("rsp_idle", rsp_valid, 0);
            end
            if (exp_idx >= 0) begin
                e.id  = exp_idx;
                e.p   = {{W{1'b0}}, req_a[exp_idx*W +: W]} * {{W{1'b0}}, req_b[exp_idx*W +: W]};
                e.tag = req_tag[exp_idx*TW +: TW];
                e.due = k + LAT + 2;
                q.push_back(e);
                ptr_m = (exp_idx + 1) % N;
            end
        end
    end

    task automatic wait_drain(input string nm, input bit need_ops, input int lim);
        int c;
        bit done;
        c = 0;
        done = 1'b0;
        while (!done && c < lim) begin
            @(negedge clk);
            c++;
            done = (busy == 1'b0);
            if (need_ops)
                for (int i = 0; i < N; i++) if (op_hd[i] != op_cnt[i]) done = 1'b0;
        end
        chk(nm, done, 1);
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    int zc, sn, c;
    int seq [8];
    int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    sb_word_t sbw;

    initial begin
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 2; j++) add_op(i, rand_w(), rand_w(), TW'($urandom));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_mul_in0", mul_in0, 0);
        chk("rst_mul_in1", mul_in1, 0);
        chk("rst_mul_m_i", mul_m_i, 0);
        chk("rst_busy", busy, 1);
        chk("rst_err_lat", err_lat, 0);
        @(posedge clk); #1;
        rst = 1'b0; fmode = 0;

        // Warm-up length and round-robin order with everyone requesting.
        zc = 0; sn = 0;
        for (int i = 0; i < 40 && sn < 8; i++) begin
            @(negedge clk);
            if (req_ready == '0 && sn == 0) zc++;
            else if (req_ready != '0) begin seq[sn] = oh2i(req_ready); sn++; end
        end
        chk("warmup_len", zc, 10);
        chk("rr_count", sn, 8);
        for (int i = 0; i < 8; i++) chk("rr_seq", seq[i], rr_exp[i]);
        wait_drain("rr_drain", 1'b1, 100);

        // Single op: packing, latency and routing.
        add_op(2, 3, 5, 8'h5A);
        c = 0;
        do begin @(negedge clk); c++; end while (!req_ready[2] && c < 20);
        chk("lat_grant", req_ready, 4'b0100);
        @(negedge clk);
        sbw = mul_m_i[10:0];
        chk("issue_a", mul_in0, 3);
        chk("issue_b", mul_in1, 5);
        chk("issue_sb", mul_m_i, 32'h0000_065A);
        chk("issue_id", sbw.id, 2);
        repeat (10) @(negedge clk);
        chk("lat_early", rsp_valid, 0);
        chk("lat_busy_hi", busy, 1);
        @(negedge clk);
        chk("lat_valid", rsp_valid, 4'b0100);
        chk("lat_data", rsp_data, 15);
        chk("lat_tag", rsp_tag, 8'h5A);
        chk("lat_busy_lo", busy, 0);

        // Back-to-back mixed traffic.
        for (int i = 0; i < 20; i++)
            add_op($urandom_range(0, N - 1), rand_w(), rand_w(), TW'($urandom));
        wait_drain("mixed_drain", 1'b1, 400);

        // en gating mid-stream.
        for (int i = 0; i < 12; i++) add_op(i % N, rand_w(), rand_w(), TW'(i));
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("en_gate", req_ready, 0);
        end
        wait_drain("en_busy_low", 1'b0, 40);
        @(posedge clk); #1 en = 1'b1;
        wait_drain("en_drain", 1'b1, 200);

        // Reset with ops in flight: their results must never surface.
        for (int i = 0; i < N; i++) add_op(i, rand_w(), rand_w(), TW'(8'hC0 + i));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1);
        chk("midrst_rsp", rsp_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        wait_drain("midrst_drain", 1'b1, 200);

        // Multiplier one cycle slower than configured.
        chk_on = 0;
        @(posedge clk); #1;
        rst = 1'b1; fmode = 2; mlat = LAT + 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; fmode = 0;
        repeat (LAT + 2) @(posedge clk);
        #1 add_op(1, 7, 9, 8'h33);
        c = 0;
        do begin @(negedge clk); c++; end while (!req_ready[1] && c < 20);
        chk("fault_grant", req_ready, 4'b0010);
        for (int j = 1; j <= LAT + 6; j++) begin
            @(negedge clk);
            chk("fault_err_lat", err_lat, (j >= 12));
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("fault_err_clr", err_lat, 0);
        @(posedge clk); #1 rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
